// File: rtl/uart_tx_scheduler_if.sv
// Write port of the UART register block plus its frame-complete status.
// The scheduler drives the write strobe/address/data; the register block
// answers with wack and reports tx_done.
interface uart_tx_scheduler_if;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        wack;
    logic        tx_done;

    modport master (output waddr, output wdata, output wr_en, input wack, input tx_done);
    modport slave  (input waddr, input wdata, input wr_en, output wack, output tx_done);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// requesters. Each frame is a TX data write, a START write and a wait for
// the frame-complete edge; line configuration is pushed only between frames.
module uart_tx_scheduler #(
    parameter int          NUM_REQ        = 4,
    parameter logic [4:0]  CFG_DEFAULT    = 5'b00011,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   timeout,
    output logic                   busy,
    input  logic [4:0]             cfg_in,
    input  logic                   cfg_update,
    uart_tx_scheduler_if.master    bus
);
    localparam int PW = $clog2(NUM_REQ);

    localparam logic [11:0] ADDR_TX   = 12'h000;
    localparam logic [11:0] ADDR_CFG  = 12'h008;
    localparam logic [11:0] ADDR_CTRL = 12'h00C;

    typedef enum logic [2:0] {
        IDLE, CFG_WR, CFG_ACK, DATA_WR, DATA_ACK, START_WR, START_ACK, WAIT_DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [PW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]  owner_reg, owner_next;
    logic [PW-1:0]  pick, owner_succ;
    logic           pick_valid;
    logic [4:0]     cfg_shadow_reg;
    logic           cfg_pending_reg;
    logic           clear_pending, restore_pending;
    logic           tx_done_q_reg;
    logic           tx_edge, limit_hit;
    logic [15:0]    counter_reg;
    logic [11:0]    waddr_reg;
    logic [31:0]    wdata_reg;
    logic           wr_en_int;
    logic [7:0]     req_byte [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    assign tx_edge    = bus.tx_done & ~tx_done_q_reg;
    assign limit_hit  = (counter_reg == TIMEOUT_CYCLES);
    assign owner_succ = (owner_reg == PW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
    assign busy       = (state_reg != IDLE);
    assign bus.wr_en  = wr_en_int;
    assign bus.waddr  = waddr_reg;
    assign bus.wdata  = wdata_reg;

    // Round-robin pick: scan from rr_ptr upward, the lowest offset wins.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_p;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx   = (int'(rr_ptr_reg) + k) % NUM_REQ;
            idx_p = PW'(idx);
            if (req[idx_p]) begin
                pick       = idx_p;
                pick_valid = 1'b1;
            end
        end
    end

    // Next-state and per-state strobes; an abort returns to IDLE like a completion.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        rr_ptr_next     = rr_ptr_reg;
        gnt             = '0;
        done            = '0;
        timeout         = 1'b0;
        wr_en_int       = 1'b0;
        clear_pending   = 1'b0;
        restore_pending = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cfg_pending_reg) begin
                    state_next = CFG_WR;
                end else if (pick_valid) begin
                    owner_next = pick;
                    state_next = DATA_WR;
                end
            end
            CFG_WR: begin
                wr_en_int     = 1'b1;
                clear_pending = 1'b1;
                state_next    = CFG_ACK;
            end
            CFG_ACK: begin
                if (bus.wack) begin
                    state_next = IDLE;
                end else if (limit_hit) begin
                    timeout         = 1'b1;
                    restore_pending = 1'b1;
                    state_next      = IDLE;
                end
            end
            DATA_WR: begin
                wr_en_int      = 1'b1;
                gnt[owner_reg] = 1'b1;
                state_next     = DATA_ACK;
            end
            DATA_ACK: begin
                if (bus.wack) begin
                    state_next = START_WR;
                end else if (limit_hit) begin
                    timeout     = 1'b1;
                    rr_ptr_next = owner_succ;
                    state_next  = IDLE;
                end
            end
            START_WR: begin
                wr_en_int  = 1'b1;
                state_next = START_ACK;
            end
            START_ACK: begin
                if (bus.wack) begin
                    state_next = WAIT_DONE;
                end else if (limit_hit) begin
                    timeout     = 1'b1;
                    rr_ptr_next = owner_succ;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_edge) begin
                    done[owner_reg] = 1'b1;
                    rr_ptr_next     = owner_succ;
                    state_next      = IDLE;
                end else if (limit_hit) begin
                    timeout     = 1'b1;
                    rr_ptr_next = owner_succ;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, arbitration pointer, owner, edge detector and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            tx_done_q_reg <= 1'b0;
            counter_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            owner_reg     <= owner_next;
            tx_done_q_reg <= bus.tx_done;
            if (state_next != state_reg) begin
                counter_reg <= '0;
            end else if (state_reg == CFG_ACK || state_reg == DATA_ACK ||
                         state_reg == START_ACK || state_reg == WAIT_DONE) begin
                counter_reg <= counter_reg + 16'd1;
            end
        end
    end

    // Configuration shadow; an update landing on the CFG write keeps it pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_shadow_reg  <= CFG_DEFAULT;
            cfg_pending_reg <= 1'b1;
        end else if (cfg_update) begin
            cfg_shadow_reg  <= cfg_in;
            cfg_pending_reg <= 1'b1;
        end else if (clear_pending) begin
            cfg_pending_reg <= 1'b0;
        end else if (restore_pending) begin
            cfg_pending_reg <= 1'b1;
        end
    end

    // Address/data are loaded on entry to a write state and held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else begin
            case (state_next)
                CFG_WR: begin
                    waddr_reg <= ADDR_CFG;
                    wdata_reg <= {27'b0, (cfg_update ? cfg_in : cfg_shadow_reg)};
                end
                DATA_WR: begin
                    waddr_reg <= ADDR_TX;
                    wdata_reg <= {24'b0, req_byte[pick]};
                end
                START_WR: begin
                    waddr_reg <= ADDR_CTRL;
                    wdata_reg <= 32'h1;
                end
                default: ;
            endcase
        end
    end
endmodule
